// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types, constants and helpers for the 7-segment scan
//             controller (scan state enum, blank code, leading-zero mask).
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Largest display the helpers are sized for.
    localparam int MAX_DIGITS = 8;

    // Nibble value the shared segment decoder renders as all-off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Scan phase: all-off gap, then the digit slot proper.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg7_state_e;

    // Per-digit leading-zero suppression vector. Bit k (k > 0) is set when
    // digit k and every digit above it are zero. Digit 0 is never set, so a
    // value of all zeros still shows a single '0'.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] values,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < num_digits) begin
                zero_above = zero_above & (values[4*k +: 4] == 4'h0);
                mask[k]    = zero_above;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl_if
//  Purpose  : Frame-load and display-drive signal bundle of the scan
//             controller. master = frame source / observer, slave = the
//             controller itself.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic                    lz_blank;
    logic [3:0]              digit_code;
    logic [NUM_DIGITS-1:0]   an;
    logic                    dp;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output load, value_in, dp_in, en_in, lz_blank,
        input  digit_code, an, dp, frame_done, pending
    );

    modport slave (
        input  load, value_in, dp_in, en_in, lz_blank,
        output digit_code, an, dp, frame_done, pending
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_timer
//  Purpose  : Scan sequencer: BLANK/SHOW phase register, phase cycle counter
//             and digit index. Emits step at the last SHOW cycle of every
//             digit and wrap when that digit is the last of the frame.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int IDX_W        = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    output seg7_state_e      o_state,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_step,
    output logic             o_wrap
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    seg7_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             step_w;
    logic             wrap_w;

    // Next phase, counter and digit index; strobes fire on the last SHOW cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        step_w  = 1'b0;
        wrap_w  = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    step_w  = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        wrap_w = 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign o_state = state_q;
    assign o_idx   = idx_q;
    assign o_step  = step_w;
    assign o_wrap  = wrap_w;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed common-anode 7-segment scan controller with a
//             double-buffered BCD frame, per-digit enables, decimal points,
//             leading-zero suppression and an all-off gap between digits.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    // Sequencer outputs.
    seg7_state_e      w_state;
    logic [IDX_W-1:0] w_idx;
    logic             w_step;
    logic             w_wrap;

    seg7_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SHOW_CYCLES  (SHOW_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_state (w_state),
        .o_idx   (w_idx),
        .o_step  (w_step),
        .o_wrap  (w_wrap)
    );

    // Frame buffers.
    logic [VAL_W-1:0]      pnd_val_q, pnd_val_d;
    logic [NUM_DIGITS-1:0] pnd_dp_q,  pnd_dp_d;
    logic [NUM_DIGITS-1:0] pnd_en_q,  pnd_en_d;
    logic [VAL_W-1:0]      act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q,  act_dp_d;
    logic [NUM_DIGITS-1:0] act_en_q,  act_en_d;
    logic                  pending_q, pending_d;

    // Output registers.
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            code_q, code_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    // Suppression helpers.
    logic [4*MAX_DIGITS-1:0] w_lz_vals;
    logic [MAX_DIGITS-1:0]   w_lz_full;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    unused_lz_hi;
    logic [3:0]              w_nib;
    logic                    w_lit;

    // Buffer update. The commit edge is the one that closes the frame_done
    // cycle; a load on that same edge lands in the pending buffer after the
    // old contents were promoted, so pending stays set.
    always_comb begin
        pnd_val_d = pnd_val_q;
        pnd_dp_d  = pnd_dp_q;
        pnd_en_d  = pnd_en_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        pending_d = pending_q;
        if (frame_done_q) begin
            act_val_d = pnd_val_q;
            act_dp_d  = pnd_dp_q;
            act_en_d  = pnd_en_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            pnd_val_d = bus.value_in;
            pnd_dp_d  = bus.dp_in;
            pnd_en_d  = bus.en_in;
            pending_d = 1'b1;
        end
    end

    // Leading-zero mask of the active frame, widened to the helper's size.
    always_comb begin
        w_lz_vals              = '0;
        w_lz_vals[VAL_W-1:0]   = act_val_q;
        w_lz_full              = lz_mask(w_lz_vals, NUM_DIGITS);
        w_supp                 = w_lz_full[NUM_DIGITS-1:0];
    end
    assign unused_lz_hi = ^w_lz_full;

    // Drive values for the next cycle from the current scan phase and digit.
    always_comb begin
        w_nib        = act_val_q[{w_idx, 2'b00} +: 4];
        w_lit        = act_en_q[w_idx] & ~(bus.lz_blank & w_supp[w_idx]);
        an_d         = '1;
        code_d       = BLANK_CODE;
        dp_d         = 1'b1;
        frame_done_d = w_wrap;
        if ((w_state == SHOW) && w_lit) begin
            an_d[w_idx] = 1'b0;
            code_d      = w_nib;
            dp_d        = ~act_dp_q[w_idx];
        end
    end

    // Buffer and output registers; reset discards both frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pnd_val_q    <= '0;
            pnd_dp_q     <= '0;
            pnd_en_q     <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            code_q       <= BLANK_CODE;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pnd_val_q    <= pnd_val_d;
            pnd_dp_q     <= pnd_dp_d;
            pnd_en_q     <= pnd_en_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            code_q       <= code_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // step is implied by the phase change back to BLANK; only wrap is consumed.
    logic unused_step;
    assign unused_step = w_step;

    assign bus.an         = an_q;
    assign bus.digit_code = code_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle show,
//             2-cycle blank) against a frame-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int BC    = 2;
    localparam int SLOT  = SC + BC;
    localparam int FRAME = ND * SLOT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SHOW_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model ----------------
    // s_cnt counts scan cycles since reset release; position within the
    // frame decides slot and phase, the active frame decides the content.
    int          s_cnt;
    logic [15:0] act_val, pnd_val;
    logic [3:0]  act_dp, act_en, pnd_dp, pnd_en;
    bit          pnd_flag;
    logic [3:0]  exp_an, exp_code;
    logic        exp_dp, exp_fd;

    always @(posedge clk or negedge rst_n) begin : model
        int p, d, q, upper;
        logic [3:0] n_an, n_code;
        logic       n_dp;
        if (!rst_n) begin
            s_cnt    = 0;
            act_val  = '0; act_dp = '0; act_en = '0;
            pnd_val  = '0; pnd_dp = '0; pnd_en = '0;
            pnd_flag = 1'b0;
            exp_an   = 4'hF; exp_code = 4'hF; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            p      = s_cnt % FRAME;
            d      = p / SLOT;
            q      = p % SLOT;
            n_an   = 4'hF;
            n_code = 4'hF;
            n_dp   = 1'b1;
            if (q >= BC) begin
                upper = int'(act_val) >> (4 * d);
                if (act_en[d] && !(bus.lz_blank && d > 0 && upper == 0)) begin
                    n_an   = 4'hF ^ (4'b0001 << d);
                    n_code = 4'(upper % 16);
                    n_dp   = !act_dp[d];
                end
            end
            if (exp_fd) begin
                act_val  = pnd_val; act_dp = pnd_dp; act_en = pnd_en;
                pnd_flag = 1'b0;
            end
            if (bus.load) begin
                pnd_val  = bus.value_in; pnd_dp = bus.dp_in; pnd_en = bus.en_in;
                pnd_flag = 1'b1;
            end
            exp_an   = n_an;
            exp_code = n_code;
            exp_dp   = n_dp;
            exp_fd   = (p == FRAME - 1);
            s_cnt++;
        end
    end

    // Every-cycle comparison of all outputs.
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({bus.an, bus.digit_code, bus.dp, bus.frame_done, bus.pending} !==
                {exp_an, exp_code, exp_dp, exp_fd, pnd_flag}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t an got %b want %b code got %h want %h dp got %b want %b fd got %b want %b pend got %b want %b",
                         $time, bus.an, exp_an, bus.digit_code, exp_code, bus.dp, exp_dp,
                         bus.frame_done, exp_fd, bus.pending, pnd_flag);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no frame_done want pulse", tag);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
        bus.load     = 1'b1;
        bus.value_in = v;
        bus.en_in    = en;
        bus.dp_in    = dpv;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, bad;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.en_in    = '0;
        bus.lz_blank = 1'b0;
        skip(3);
        chk_on = 1'b1;
        check_lit("reset_an",   32'(bus.an), 32'hF);
        check_lit("reset_code", 32'(bus.digit_code), 32'hF);
        check_lit("reset_dp",   32'(bus.dp), 32'h1);
        check_lit("reset_pend", 32'(bus.pending), 32'h0);
        rst_n = 1'b1;

        // First frame: 1234, all enabled.
        do_load(16'h1234, 4'hF, 4'h0);
        check_lit("pend_after_load", 32'(bus.pending), 32'h1);
        wait_fd("first");
        check_lit("pend_at_fd", 32'(bus.pending), 32'h1);
        skip(1);
        check_lit("pend_after_fd", 32'(bus.pending), 32'h0);
        skip(2);
        check_lit("d0_an",   32'(bus.an), 32'hE);
        check_lit("d0_code", 32'(bus.digit_code), 32'h4);
        n = 3;
        while (bus.frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_lit("fd_period", 32'(n), 32'(FRAME));

        // Leading-zero suppression.
        bus.lz_blank = 1'b1;
        do_load(16'h0050, 4'hF, 4'h0);
        wait_fd("lz_commit");
        skip(3);
        check_lit("lz_d0_code", 32'(bus.digit_code), 32'h0);
        skip(10);
        check_lit("lz_d1_code", 32'(bus.digit_code), 32'h5);
        check_lit("lz_d1_an",   32'(bus.an), 32'hD);
        skip(10);
        check_lit("lz_d2_an",   32'(bus.an), 32'hF);
        wait_fd("lz_frame");
        bus.lz_blank = 1'b0;
        wait_fd("nolz_frame");

        // Sparse enables with a decimal point.
        do_load(16'h9876, 4'b0101, 4'b0100);
        wait_fd("en_commit");
        skip(23);
        check_lit("en_d2_dp", 32'(bus.dp), 32'h0);
        wait_fd("en_frame");

        // Mid-frame reloads and a load coincident with frame_done.
        skip(15);
        do_load(16'h1111, 4'hF, 4'h0);
        skip(5);
        do_load(16'h2222, 4'hF, 4'h0);
        wait_fd("reload_commit");
        do_load(16'hABCF, 4'hF, 4'h0);
        check_lit("pend_coincident", 32'(bus.pending), 32'h1);
        wait_fd("show_2222");
        wait_fd("show_abcf");

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0)
                do_load(rand_val(), 4'($urandom_range(15)), 4'($urandom_range(15)));
            else
                @(negedge clk);
            if ($urandom_range(49) == 0) bus.lz_blank = ~bus.lz_blank;
        end

        // Reset during SHOW of digit 2 with a frame pending.
        wait_fd("pre_reset");
        do_load(rand_val(), 4'hF, 4'hF);
        skip(23);
        #2 rst_n = 1'b0;
        #1;
        check_lit("arst_an",   32'(bus.an), 32'hF);
        check_lit("arst_code", 32'(bus.digit_code), 32'hF);
        check_lit("arst_dp",   32'(bus.dp), 32'h1);
        check_lit("arst_pend", 32'(bus.pending), 32'h0);
        skip(2);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            @(negedge clk);
            if (bus.an !== 4'hF) bad++;
        end
        check_lit("post_reset_dark", 32'(bad), 32'h0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Holds a double-buffered BCD frame and steps through the digits one at a time.
- For the active digit it presents the BCD nibble to the shared BCD-to-segment decoder and drives the active-low anode enables.
- Inserts an all-off blanking gap between digits to prevent ghosting. Frame updates take effect only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SHOW_CYCLES, 100000, clock cycles each digit is lit.
- BLANK_CYCLES, 2000, clock cycles of all-off gap before each digit (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  strobe; captures value_in/dp_in/en_in into the pending buffer.
- value_in  in  4*NUM_DIGITS  BCD digits; digit k = value_in[4k+3:4k], digit 0 = rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = on.
- en_in  in  NUM_DIGITS  digit enable mask, 1 = digit may light.
- lz_blank  in  1  leading-zero suppression enable (live, not buffered).
- digit_code  out  4  BCD nibble to the segment decoder; 4'hF = blank.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all 1s.
- dp  out  1  decimal-point segment, active-low.
- frame_done  out  1  one-cycle pulse at the end of the last digit of each frame.
- pending  out  1  a loaded frame is waiting to be committed.

Behaviour:
- Reset (async assert, sync deassert):
  - an = all 1s, digit_code = 4'hF, dp = 1, frame_done = 0, pending = 0.
  - Active and pending buffers cleared: value 0, dp 0, en 0.
  - FSM in BLANK, idx = 0, cycle counter = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Buffering:
  - load = 1 on a clock edge copies the inputs into the pending buffer and sets pending.
  - A second load before commit overwrites the pending buffer; pending stays 1.
  - Commit occurs on the cycle frame_done pulses: pending buffer copied to active buffer, pending cleared.
  - load and commit in the same cycle: commit uses the old pending contents, the new data is stored, and pending remains 1.
- FSM states:
  - BLANK: an = all 1s, digit_code = 4'hF, dp = 1. Lasts BLANK_CYCLES, then moves to SHOW.
  - SHOW: lasts SHOW_CYCLES.
    - If the digit is lit: an[idx] = 0, digit_code = active nibble[idx], dp = ~active_dp[idx].
    - If the digit is unlit: outputs are the same as in BLANK.
    - On exit: idx increments. If idx was NUM_DIGITS-1, idx wraps to 0, frame_done pulses and commit occurs; then the FSM returns to BLANK.
- Digit lit condition: en[idx] = 1 and the digit is not suppressed.
- Suppression (lz_blank = 1):
  - Digit k>0 is suppressed when it and every higher digit equals 0.
  - Digit 0 is never suppressed.
  - A suppressed digit also blanks its decimal point.
- Nibbles 10..15 are passed through unchanged; the decoder renders them blank.
- Counter width: clog2(max(SHOW_CYCLES, BLANK_CYCLES)).
- Frame period = NUM_DIGITS*(SHOW_CYCLES+BLANK_CYCLES) cycles, exactly.
- Reset mid-frame immediately forces the reset values. Any pending frame is discarded.

Decomposition:
- Shared package seg7_pkg holds:
  - state enum {BLANK, SHOW};
  - BLANK_CODE = 4'hF;
  - function lz_mask(values) returning the per-digit suppression vector.
- One sub-module, seg7_scan_timer: counter plus state register, emitting step and wrap strobes. Buffers, suppression and output registers stay in the top.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=8, BLANK_CYCLES=2):
- Reset then load value_in=16'h1234, en_in=4'hF, dp_in=0:
  - pending=1 until the first frame_done, then 0.
  - Next frame shows an=1110/code 4, 1101/3, 1011/2, 0111/1, each for 8 cycles separated by 2 all-1s cycles.
  - frame_done period is exactly 40 cycles.
- value 16'h0050, lz_blank=1, en=4'hF:
  - digit 3 and digit 2 show an=1111, code F.
  - digit 1 shows 5, digit 0 shows 0.
  - With lz_blank=0, all four digits are lit: 0,0,5,0.
- en_in=4'b0101, dp_in=4'b0100, value 16'h9876:
  - digits 0 and 2 are lit (6 and 8), with dp=0 only on digit 2.
  - digits 1 and 3 slots are all-off but keep their 8-cycle timing.
- Load 16'h1111 mid-frame, then 16'h2222 before frame_done:
  - the current frame is unchanged.
  - the next frame shows 2222.
  - load coincident with frame_done leaves pending=1.
- Value 16'hABCF: digit_code carries F, C, B, A on digits 0..3 with anodes active; decoder output is blank.
- Assert rst_n=0 during SHOW of digit 2 with pending=1:
  - outputs go to reset values within the same cycle, asynchronously.
  - after release the first SHOW is digit 0 with value 0 and en 0, so an stays 1111.
